// File: rtl/cci_mpf_svc_vtp_tlb_dm.sv
// Direct-mapped 4KB TLB front end of the VTP translation service: hits answered in
// two cycles, misses queued and resolved one at a time through the walker. Optional: MPF_VTP_TLB_STATS_EN.
module cci_mpf_svc_vtp_tlb_dm #(
    parameter int VA_PAGE_BITS = 36,
    parameter int PA_PAGE_BITS = 36,
    parameter int TAG_BITS     = 4,
    parameter int NUM_ENTRIES  = 512,
    parameter int MISS_DEPTH   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    lookupEn,
    input  logic [VA_PAGE_BITS-1:0] lookupPageVA,
    input  logic [TAG_BITS-1:0]     lookupTag,
    output logic                    lookupRdy,
    output logic                    lookupRspValid,
    output logic [PA_PAGE_BITS-1:0] lookupRspPagePA,
    output logic [TAG_BITS-1:0]     lookupRspTag,
    output logic                    lookupRspIsBigPage,
    output logic                    walkReqEn,
    output logic [VA_PAGE_BITS-1:0] walkReqVA,
    input  logic                    walkReqRdy,
    input  logic                    fillEn,
    input  logic [VA_PAGE_BITS-1:0] fillVA,
    input  logic [PA_PAGE_BITS-1:0] fillPA,
    input  logic                    fillBigPage,
    output logic                    fillRdy,
    output logic [31:0]             statHits,
    output logic [31:0]             statMisses
);
    localparam int IDX = $clog2(NUM_ENTRIES);
    localparam int VT  = VA_PAGE_BITS - IDX;
    localparam int PW  = $clog2(MISS_DEPTH);

    typedef enum logic [2:0] {IDLE, PROBE, PROBE_WAIT, WALK_REQ, WAIT_FILL} state_t;
    state_t state_q, state_d;

    logic [NUM_ENTRIES-1:0]  valid_q;
    logic [VT-1:0]           vtag_ram [NUM_ENTRIES];
    logic [PA_PAGE_BITS-1:0] pa_ram   [NUM_ENTRIES];
    logic                    big_ram  [NUM_ENTRIES];

    logic [VA_PAGE_BITS-1:0] mf_va  [MISS_DEPTH];
    logic [TAG_BITS-1:0]     mf_tag [MISS_DEPTH];
    logic [PW-1:0]           mf_wr_q, mf_rd_q;
    logic [PW:0]             mf_cnt_q;
    logic                    mf_push, mf_pop;
    logic [VA_PAGE_BITS-1:0] head_va;
    logic [TAG_BITS-1:0]     head_tag;

    logic                    probe_inject, walk_req;
    logic                    s0_valid, s0_probe;
    logic [VA_PAGE_BITS-1:0] s0_va;
    logic [TAG_BITS-1:0]     s0_tag;
    logic                    s1_valid_q, s1_probe_q;
    logic [VA_PAGE_BITS-1:0] s1_va_q;
    logic [TAG_BITS-1:0]     s1_tag_q;
    logic                    s2_valid_q, s2_probe_q;
    logic [VA_PAGE_BITS-1:0] s2_va_q;
    logic [TAG_BITS-1:0]     s2_tag_q;
    logic                    s2_ent_valid_q, s2_big_q;
    logic [VT-1:0]           s2_vtag_q;
    logic [PA_PAGE_BITS-1:0] s2_pa_q;
    logic                    s2_hit;

    assign head_va  = mf_va[mf_rd_q];
    assign head_tag = mf_tag[mf_rd_q];

    // Three free slots guarantee room for the two lookups already in S1/S2 plus this one.
    assign lookupRdy = !reset && (mf_cnt_q < (PW+1)'(MISS_DEPTH - 2)) && !probe_inject;
    assign fillRdy   = !reset;

    assign s0_probe = probe_inject;
    assign s0_valid = probe_inject || (lookupEn && lookupRdy);
    assign s0_va    = probe_inject ? head_va  : lookupPageVA;
    assign s0_tag   = probe_inject ? head_tag : lookupTag;

    // Entry read is registered, so a fill landing in the same cycle is not seen by this compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s0_valid;
            s2_valid_q <= s1_valid_q;
        end
        s1_probe_q     <= s0_probe;
        s1_va_q        <= s0_va;
        s1_tag_q       <= s0_tag;
        s2_probe_q     <= s1_probe_q;
        s2_va_q        <= s1_va_q;
        s2_tag_q       <= s1_tag_q;
        s2_ent_valid_q <= valid_q[s1_va_q[IDX-1:0]];
        s2_vtag_q      <= vtag_ram[s1_va_q[IDX-1:0]];
        s2_pa_q        <= pa_ram[s1_va_q[IDX-1:0]];
        s2_big_q       <= big_ram[s1_va_q[IDX-1:0]];
    end

    assign s2_hit = s2_ent_valid_q && (s2_vtag_q == s2_va_q[VA_PAGE_BITS-1:IDX]);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (fillEn) begin
            valid_q[fillVA[IDX-1:0]] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fillEn && !reset) begin
            vtag_ram[fillVA[IDX-1:0]] <= fillVA[VA_PAGE_BITS-1:IDX];
            pa_ram[fillVA[IDX-1:0]]   <= fillPA;
            big_ram[fillVA[IDX-1:0]]  <= fillBigPage;
        end
    end

    assign mf_push = s2_valid_q && !s2_probe_q && !s2_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            mf_wr_q  <= '0;
            mf_rd_q  <= '0;
            mf_cnt_q <= '0;
        end else begin
            if (mf_push) begin
                mf_va[mf_wr_q]  <= s2_va_q;
                mf_tag[mf_wr_q] <= s2_tag_q;
                mf_wr_q         <= mf_wr_q + 1'b1;
            end
            if (mf_pop) begin
                mf_rd_q <= mf_rd_q + 1'b1;
            end
            mf_cnt_q <= mf_cnt_q + (PW+1)'(mf_push) - (PW+1)'(mf_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (mf_cnt_q != '0) state_d = PROBE;
            PROBE:      state_d = PROBE_WAIT;
            PROBE_WAIT: if (s2_valid_q && s2_probe_q) state_d = s2_hit ? IDLE : WALK_REQ;
            WALK_REQ:   if (walkReqRdy) state_d = WAIT_FILL;
            WAIT_FILL:  if (fillEn && (fillVA == head_va)) state_d = PROBE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        probe_inject = (state_q == PROBE);
        walk_req     = (state_q == WALK_REQ);
        mf_pop       = (state_q == PROBE_WAIT) && s2_valid_q && s2_probe_q && s2_hit;
    end

    assign walkReqEn          = !reset && walk_req;
    assign walkReqVA          = walkReqEn ? head_va : '0;
    assign lookupRspValid     = !reset && s2_valid_q && s2_hit;
    assign lookupRspPagePA    = lookupRspValid ? s2_pa_q  : '0;
    assign lookupRspTag       = lookupRspValid ? s2_tag_q : '0;
    assign lookupRspIsBigPage = lookupRspValid && s2_big_q;

`ifdef MPF_VTP_TLB_STATS_EN
    logic [31:0] hits_q, misses_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (s2_valid_q && !s2_probe_q) begin
            if (s2_hit && (hits_q != '1)) hits_q <= hits_q + 32'd1;
            if (!s2_hit && (misses_q != '1)) misses_q <= misses_q + 32'd1;
        end
    end

    assign statHits   = hits_q;
    assign statMisses = misses_q;
`else
    assign statHits   = '0;
    assign statMisses = '0;
`endif
endmodule

// File: tb/tb_cci_mpf_svc_vtp_tlb_dm.sv
// Randomized scoreboard bench for cci_mpf_svc_vtp_tlb_dm: a page-table map supplies walker
// fills, every accepted lookup is queued with its expected translation and matched by tag.
module tb_cci_mpf_svc_vtp_tlb_dm;
    logic        clk = 1'b0;
    logic        reset;
    logic        lookupEn;
    logic [35:0] lookupPageVA;
    logic [3:0]  lookupTag;
    logic        lookupRdy, lookupRspValid, lookupRspIsBigPage;
    logic [35:0] lookupRspPagePA;
    logic [3:0]  lookupRspTag;
    logic        walkReqEn, walkReqRdy;
    logic [35:0] walkReqVA;
    logic        fillEn, fillBigPage, fillRdy;
    logic [35:0] fillVA, fillPA;
    logic [31:0] statHits, statMisses;

    cci_mpf_svc_vtp_tlb_dm #(
        .VA_PAGE_BITS(36), .PA_PAGE_BITS(36), .TAG_BITS(4), .NUM_ENTRIES(512), .MISS_DEPTH(8)
    ) dut (
        .clk(clk), .reset(reset),
        .lookupEn(lookupEn), .lookupPageVA(lookupPageVA), .lookupTag(lookupTag), .lookupRdy(lookupRdy),
        .lookupRspValid(lookupRspValid), .lookupRspPagePA(lookupRspPagePA), .lookupRspTag(lookupRspTag),
        .lookupRspIsBigPage(lookupRspIsBigPage),
        .walkReqEn(walkReqEn), .walkReqVA(walkReqVA), .walkReqRdy(walkReqRdy),
        .fillEn(fillEn), .fillVA(fillVA), .fillPA(fillPA), .fillBigPage(fillBigPage), .fillRdy(fillRdy),
        .statHits(statHits), .statMisses(statMisses)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  tag;
        logic [35:0] va;
        logic [35:0] pa;
        logic        big;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [3:0]  rsp_order[$];
    logic [36:0] pt_map[logic [35:0]];
    int          walk_cnt[logic [35:0]];
    logic [36:0] fill_q[$];
    logic [35:0] fill_va_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lookups_since_reset = 0;
    bit          walk_hold = 1'b0;
    bit          fill_hold = 1'b0;
    bit          rand_fills = 1'b0;
    bit          wk_pending = 1'b0;
    logic [35:0] wk_va = '0;
    int          wk_delay = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Page table: explicit entries override a fixed arithmetic mapping.
    function automatic logic [36:0] pt(input logic [35:0] va);
        if (pt_map.exists(va)) return pt_map[va];
        return {va[0] ^ va[5], (va * 36'd3) ^ 36'h900001234};
    endfunction

    function automatic bit tag_busy(input logic [3:0] t);
        foreach (sb[i]) if (sb[i].tag == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit va_pending(input logic [35:0] va);
        foreach (sb[i]) if (sb[i].va == va) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_lookup(input logic [35:0] va, input logic [3:0] tag, input int lat);
        logic [36:0] e;
        e = pt(va);
        lookupEn = 1'b1;
        lookupPageVA = va;
        lookupTag = tag;
        for (int w = 0; w < 3000; w++) begin
            @(negedge clk);
            if (lookupRdy) begin
                sb.push_back('{tag: tag, va: va, pa: e[35:0], big: e[36], acc: cyc, lat: lat});
                lookups_since_reset++;
                @(posedge clk);
                #1;
                lookupEn = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL lookup_accept_timeout actual=rdy_low required=accepted tag=%0d", tag);
        @(posedge clk);
        #1;
        lookupEn = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int w = 0; w < 4000; w++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL %s_drain_timeout actual=%0d_pending required=0_pending", name, sb.size());
        sb.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_walk_taken(input string name);
        for (int w = 0; w < 200; w++) begin
            if (wk_pending) begin
                cycles(2);
                return;
            end
            cycles(1);
        end
        chk({name, "_walk_taken"}, 64'(wk_pending), 64'd1);
    endtask

    function automatic bit order_is(input logic [3:0] a, input logic [3:0] b);
        return (rsp_order.size() == 2) && (rsp_order[0] == a) && (rsp_order[1] == b);
    endfunction

    // Monitor: match every response against the scoreboard by tag.
    initial begin
        forever begin
            @(negedge clk);
            if (lookupRspValid) begin
                int hit_i;
                hit_i = -1;
                foreach (sb[i]) if (hit_i < 0 && sb[i].tag == lookupRspTag) hit_i = i;
                checks++;
                if (hit_i < 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected actual=tag%0d required=no_response", lookupRspTag);
                end else begin
                    if (lookupRspPagePA !== sb[hit_i].pa || lookupRspIsBigPage !== sb[hit_i].big ||
                        (sb[hit_i].lat >= 0 && (cyc - sb[hit_i].acc) != sb[hit_i].lat)) begin
                        errors++;
                        $display("FAIL rsp_tag%0d actual=pa0x%0h/big%0d/lat%0d required=pa0x%0h/big%0d/lat%0d",
                                 lookupRspTag, lookupRspPagePA, lookupRspIsBigPage, cyc - sb[hit_i].acc,
                                 sb[hit_i].pa, sb[hit_i].big, sb[hit_i].lat);
                    end
                    rsp_order.push_back(lookupRspTag);
                    sb.delete(hit_i);
                end
            end
        end
    end

    // Walker model: accepts walks, returns page-table fills, plus queued and random extra fills.
    initial begin
        walkReqRdy = 1'b0;
        fillEn = 1'b0;
        fillVA = '0;
        fillPA = '0;
        fillBigPage = 1'b0;
        forever begin
            @(negedge clk);
            walkReqRdy = 1'b0;
            fillEn = 1'b0;
            if (fill_q.size() > 0) begin
                logic [36:0] f;
                f = fill_q.pop_front();
                fillEn = 1'b1;
                fillVA = fill_va_q.pop_front();
                fillPA = f[35:0];
                fillBigPage = f[36];
            end else if (wk_pending && !fill_hold && wk_delay == 0) begin
                logic [36:0] f;
                f = pt(wk_va);
                fillEn = 1'b1;
                fillVA = wk_va;
                fillPA = f[35:0];
                fillBigPage = f[36];
                wk_pending = 1'b0;
            end else begin
                if (wk_pending && wk_delay > 0) wk_delay--;
                if (!wk_pending && walkReqEn && !walk_hold && $urandom_range(0, 1) == 0) begin
                    chk("walk_va_outstanding", 64'(va_pending(walkReqVA)), 64'd1);
                    walkReqRdy = 1'b1;
                    wk_va = walkReqVA;
                    wk_pending = 1'b1;
                    wk_delay = int'($urandom_range(0, 4));
                    if (walk_cnt.exists(walkReqVA)) walk_cnt[walkReqVA]++;
                    else walk_cnt[walkReqVA] = 1;
                end else if (rand_fills && $urandom_range(0, 9) == 0) begin
                    logic [35:0] rv;
                    logic [36:0] f;
                    rv = ((36'($urandom_range(0, 2)) + 36'h40) << 9) | 36'($urandom_range(0, 5) * 37);
                    f = pt(rv);
                    fillEn = 1'b1;
                    fillVA = rv;
                    fillPA = f[35:0];
                    fillBigPage = f[36];
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        lookupEn = 1'b0;
        lookupPageVA = '0;
        lookupTag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_lookupRdy", 64'(lookupRdy), 64'd0);
        chk("reset_rspValid", 64'(lookupRspValid), 64'd0);
        chk("reset_walkReqEn", 64'(walkReqEn), 64'd0);
        chk("reset_fillRdy", 64'(fillRdy), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_fillRdy", 64'(fillRdy), 64'd1);
        chk("post_reset_lookupRdy", 64'(lookupRdy), 64'd1);
        cycles(1);

        // Directed fill then hit.
        pt_map[36'h123] = {1'b0, 36'h456};
        fill_va_q.push_back(36'h123);
        fill_q.push_back({1'b0, 36'h456});
        cycles(3);
        do_lookup(36'h123, 4'd3, 2);
        drain("fill_hit");

        // Miss on an empty entry: one walk, response with the walked PA.
        pt_map[36'h200] = {1'b0, 36'h9};
        do_lookup(36'h200, 4'd1, -1);
        drain("single_miss");
        chk("single_miss_walks", 64'(walk_cnt[36'h200]), 64'd1);

        // Two misses to one page: one walk, answered in order.
        pt_map[36'h280] = {1'b1, 36'h77};
        rsp_order.delete();
        do_lookup(36'h280, 4'd1, -1);
        do_lookup(36'h280, 4'd2, -1);
        drain("double_miss");
        chk("double_miss_walks", 64'(walk_cnt[36'h280]), 64'd1);
        chk("double_miss_order", 64'(order_is(4'd1, 4'd2)), 64'd1);

        // Hit under a pending walk overtakes it.
        rsp_order.delete();
        fill_hold = 1'b1;
        do_lookup(36'h300, 4'd5, -1);
        wait_walk_taken("hum");
        do_lookup(36'h123, 4'd6, 2);
        cycles(4);
        fill_hold = 1'b0;
        drain("hit_under_miss");
        chk("hit_under_miss_order", 64'(order_is(4'd6, 4'd5)), 64'd1);

        // Stalled walker: six misses exhaust lookup credit, then all drain.
        walk_hold = 1'b1;
        for (int k = 0; k < 6; k++) do_lookup(36'h1000 + 36'(k * 7), 4'(8 + k), -1);
        cycles(6);
        @(negedge clk);
        chk("stall_lookupRdy", 64'(lookupRdy), 64'd0);
        chk("stall_walkReqEn", 64'(walkReqEn), 64'd1);
        cycles(1);
        walk_hold = 1'b0;
        drain("stall");

        // Reset while waiting for a fill; the late fill is still written.
        fill_hold = 1'b1;
        do_lookup(36'h3A0, 4'd7, -1);
        wait_walk_taken("rst");
        cycles(2);
        reset = 1'b1;
        sb.delete();
        lookups_since_reset = 0;
        cycles(2);
        @(negedge clk);
        chk("midwalk_reset_lookupRdy", 64'(lookupRdy), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("after_reset_walkReqEn", 64'(walkReqEn), 64'd0);
        chk("after_reset_lookupRdy", 64'(lookupRdy), 64'd1);
        cycles(15);
        fill_hold = 1'b0;
        cycles(10);
        do_lookup(36'h3A0, 4'd8, 2);
        drain("late_fill");
        chk("late_fill_walks", 64'(walk_cnt[36'h3A0]), 64'd1);

        // Randomized traffic with conflicting indices and stray fills.
        rand_fills = 1'b1;
        for (int n = 0; n < 250; n++) begin
            logic [3:0]  t;
            logic [35:0] va;
            int          g;
            g = 0;
            while (sb.size() >= 16 && g < 2000) begin
                cycles(1);
                g++;
            end
            if (sb.size() >= 16) begin
                chk("tag_pool_free", 64'(sb.size()), 64'd15);
                break;
            end
            do t = 4'($urandom_range(0, 15)); while (tag_busy(t));
            va = ((36'($urandom_range(0, 2)) + 36'h40) << 9) | 36'($urandom_range(0, 5) * 37);
            do_lookup(va, t, -1);
            cycles(int'($urandom_range(0, 2)));
        end
        drain("random");
        rand_fills = 1'b0;
        cycles(5);

`ifdef MPF_VTP_TLB_STATS_EN
        chk("stat_total", 64'(statHits) + 64'(statMisses), 64'(lookups_since_reset));
`else
        chk("stat_hits_tied", 64'(statHits), 64'd0);
        chk("stat_misses_tied", 64'(statMisses), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
